bspline_eval_scheduler: RTL
===========================

# bspline_eval_scheduler

Round-robin scheduler that shares one B-spline evaluator among NUM_REQ requesters (KAN edge units). It accepts one request at a time, drives the evaluator's enable/input and coefficient-bank select for the whole evaluation, and returns the result tagged with the requester ID. A watchdog aborts evaluations that never complete.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 16, input/result width
- BANK_W, 3, width of coefficient/knot bank select
- TIMEOUT_CYCLES, 64, max cycles in EVAL before abort
- ID_W, $clog2(NUM_REQ), requester ID width (derived)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept
- req_data  in  NUM_REQ*DATA_WIDTH  packed input values; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_bank  in  NUM_REQ*BANK_W  packed bank selects; same packing rule
- eval_enable  out  1  evaluator enable
- eval_input  out  DATA_WIDTH  evaluator input_value
- eval_bank  out  BANK_W  selects coefficient/knot bank feeding the evaluator
- eval_valid  in  1  evaluator valid_out
- eval_result  in  DATA_WIDTH  evaluator output_value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  DATA_WIDTH  result (0 on timeout)
- rsp_id  out  ID_W  requester index
- rsp_timeout  out  1  response is an aborted evaluation
- busy  out  1  state != IDLE
- err_count  out  8  saturating timeout counter

## Operation
- States: IDLE, ISSUE, EVAL, RESP.
- IDLE: round-robin search from pointer `rr_ptr`. The first i (mod NUM_REQ) with req_valid[i] is granted.
  - req_ready[i] = 1 combinationally in that cycle.
  - Latch req_data/req_bank into eval_input/eval_bank, and i into rsp_id.
  - rr_ptr <= (i+1) mod NUM_REQ; go to ISSUE.
  - No valid: stay, req_ready = 0.
- Requester rule: req_valid, req_data and req_bank must be held until req_ready. Dropping valid before grant is legal and is never granted.
- ISSUE (1 cycle): eval_enable = 1, eval_valid ignored (evaluator clears stale valid and latches input); clear watchdog; go to EVAL.
- EVAL: eval_enable = ~eval_valid (combinational). Enable drops in the same cycle valid is seen, so the evaluator parks in stage 0 with valid held.
  - eval_valid = 1: rsp_data <= eval_result, rsp_timeout <= 0, go to RESP.
  - Otherwise watchdog increments. When the watchdog reaches TIMEOUT_CYCLES-1 without valid: rsp_data <= 0, rsp_timeout <= 1, err_count += 1 (saturates at 255), go to RESP.
  - After a timeout the evaluator state is undefined. Recovery is the system's job; the scheduler continues normally.
- RESP: rsp_valid = 1; rsp_data, rsp_id and rsp_timeout are stable. On rsp_ready go to IDLE. No new grant happens in that same cycle; the earliest next grant is the following cycle.
- eval_input and eval_bank hold their value from grant until the next grant.
- Exactly one evaluation is outstanding at any time; req_ready is zero outside IDLE.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0
  - req_ready 0, eval_enable 0, eval_input 0, eval_bank 0
  - rsp_valid 0, rsp_data 0, rsp_id 0, rsp_timeout 0
  - busy 0, err_count 0, watchdog 0
- Grant at cycle T (IDLE), ISSUE at T+1, EVAL from T+2.
  - If eval_valid rises at cycle V, rsp_valid = 1 from V+1.
  - With GRID_SIZE = 8, eval_valid rises about 19 cycles after ISSUE.
- Timeout: if the first EVAL cycle is E, rsp_valid rises at E+TIMEOUT_CYCLES.
- Backpressure: rsp_valid holds indefinitely with stable outputs; eval_enable = 0 while in RESP.
- Reset asserted mid-operation clears everything immediately (async) and drops eval_enable. The pending request is lost; the requester must still hold valid to be re-granted.
- Simultaneous requests: strict round-robin, no starvation. Worst-case wait is NUM_REQ-1 full services.

## Test plan
- Single request: req_valid[2] = 1, data 0x4000, bank 5 -> req_ready[2] for exactly 1 cycle; eval_bank = 5 and eval_input = 0x4000 through EVAL. Evaluator model returns 0x1234 -> rsp_data 0x1234, rsp_id 2, rsp_timeout 0.
- All four requesting continuously from reset -> grant order 0,1,2,3,0. rsp_id sequence matches; no requester is granted twice before the others are served.
- Stuck evaluator (eval_valid tied 0), TIMEOUT_CYCLES = 64 -> rsp_valid exactly 64 cycles after the first EVAL cycle, with rsp_timeout = 1, rsp_data = 0, err_count = 1. Run 300 times -> err_count saturates at 255.
- Backpressure: rsp_ready held low for 20 cycles -> rsp outputs stable, req_ready stays 0, eval_enable = 0. On release -> IDLE next cycle, then the next grant.
- Stale valid: eval_valid held 1 from the previous job while the new ISSUE fires -> no premature response. eval_enable is 1 in the ISSUE cycle and the result comes from the new evaluation.
- Reset pulse in the middle of EVAL -> all outputs at reset values within the same cycle. After release, the still-asserted requester 1 is granted first when rr_ptr = 0 and req_valid[0] = 0.

Source files
------------

// File: rtl/bspline_eval_scheduler.sv
// Round-robin scheduler sharing one B-spline evaluator among NUM_REQ requesters.
// One evaluation is outstanding at a time. The result goes back tagged with the
// requester ID. A watchdog turns an evaluation that never completes into a
// timeout response.
module bspline_eval_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BANK_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*BANK_W-1:0]    req_bank,
  output logic                         eval_enable,
  output logic [DATA_WIDTH-1:0]        eval_input,
  output logic [BANK_W-1:0]            eval_bank,
  input  logic                         eval_valid,
  input  logic [DATA_WIDTH-1:0]        eval_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_timeout,
  output logic                         busy,
  output logic [7:0]                   err_count
);

  // Wide enough to hold rr_ptr + offset before wrapping back into range.
  localparam int unsigned CandW = ID_W + 1;
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StEval, StResp} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] eval_input_q, eval_input_d;
  logic [BANK_W-1:0]     eval_bank_q, eval_bank_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [WdW-1:0]        wd_q, wd_d;

  logic                  grant_found;
  logic                  grant_ok;
  logic [ID_W-1:0]       grant_idx;
  logic [CandW-1:0]      cand;

  // Round-robin search: first valid requester at or after rr_ptr, modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = {1'b0, rr_ptr_q} + CandW'(k);
      if (cand >= CandW'(NUM_REQ)) begin
        cand = cand - CandW'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Grants only in IDLE. rst gates req_ready so it reads 0 while reset is held.
  assign grant_ok = grant_found && (state_q == StIdle) && !rst;

  // One-hot accept toward the granted requester.
  always_comb begin
    req_ready = '0;
    if (grant_ok) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic for the scheduler FSM, watchdog and response registers.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    eval_input_d  = eval_input_q;
    eval_bank_d   = eval_bank_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_timeout_d = rsp_timeout_q;
    err_count_d   = err_count_q;
    wd_d          = wd_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          eval_input_d = req_data[int'(grant_idx) * int'(DATA_WIDTH) +: DATA_WIDTH];
          eval_bank_d  = req_bank[int'(grant_idx) * int'(BANK_W) +: BANK_W];
          rsp_id_d     = grant_idx;
          rr_ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d      = StIssue;
        end
      end
      StIssue: begin
        // Evaluator clears its stale valid this cycle, so eval_valid is ignored.
        wd_d    = '0;
        state_d = StEval;
      end
      StEval: begin
        if (eval_valid) begin
          rsp_data_d    = eval_result;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (wd_q == WdLast) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          state_d = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      eval_input_q  <= '0;
      eval_bank_q   <= '0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_timeout_q <= 1'b0;
      err_count_q   <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      eval_input_q  <= eval_input_d;
      eval_bank_q   <= eval_bank_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_count_q   <= err_count_d;
      wd_q          <= wd_d;
    end
  end

  // Enable drops in the same cycle valid shows up so the evaluator parks with valid held.
  assign eval_enable = (state_q == StIssue) || ((state_q == StEval) && !eval_valid);
  assign eval_input  = eval_input_q;
  assign eval_bank   = eval_bank_q;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != StIdle);
  assign err_count   = err_count_q;

endmodule
